run_watchdog: RTL and testbench

//  Supervises one kernel run from ap_start to completion. Arms a countdown on
//  ap_start, reloads it on every progress pulse and on expiry requests a kernel

---
 rtl/wdog_pkg.sv | 21 ++
 rtl/run_watchdog_if.sv | 38 +++
 rtl/wdog_countdown.sv | 46 ++++
 rtl/run_watchdog.sv | 95 +++++++++
 tb/tb_run_watchdog.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/wdog_pkg.sv
// Shared types and constants for the run watchdog.
// Optional elapsed-cycle counter is enabled by defining WDOG_CYCLE_CNT_EN.
package wdog_pkg;

  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] DEFAULT_TO = 32'h7735_9400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ABORT = 2'd2,
    DONE  = 2'd3
  } wdog_state_t;

  // A zero timeout request means "use the default", so the countdown never loads 0.
  function automatic logic [CNT_W-1:0] sel_timeout(input logic [CNT_W-1:0] cfg,
                                                   input logic [CNT_W-1:0] dflt);
    return (cfg == '0) ? dflt : cfg;
  endfunction

endpackage

// File: rtl/run_watchdog_if.sv
// Host/kernel control bundle supervised by run_watchdog.
// The cycles signal exists only when WDOG_CYCLE_CNT_EN is defined.
interface run_watchdog_if
  import wdog_pkg::*;
#(
  parameter int CYC_W = 48
);

  logic             ap_start;
  logic [CNT_W-1:0] timeout_cfg;
  logic             progress;
  logic             kernel_done;
  logic             abort_req;
  logic             abort_ack;
  logic             ap_idle;
  logic             ap_done;
  logic             status_timeout;
`ifdef WDOG_CYCLE_CNT_EN
  logic [CYC_W-1:0] cycles;
`endif

  modport master (
    output ap_start, timeout_cfg, progress, kernel_done, abort_ack,
    input  abort_req, ap_idle, ap_done, status_timeout
`ifdef WDOG_CYCLE_CNT_EN
    , input cycles
`endif
  );

  modport slave (
    input  ap_start, timeout_cfg, progress, kernel_done, abort_ack,
    output abort_req, ap_idle, ap_done, status_timeout
`ifdef WDOG_CYCLE_CNT_EN
    , output cycles
`endif
  );

endinterface

// File: rtl/wdog_countdown.sv
// Loadable countdown with a latched reload value; expired_o flags cnt==1.
module wdog_countdown
  import wdog_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             reload_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] reload_q, reload_d;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d    = cnt_q;
    reload_d = reload_q;
    if (load_i) begin
      cnt_d    = load_val_i;
      reload_d = load_val_i;
    end else if (reload_i) begin
      cnt_d = reload_q;
    end else if (dec_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst_n) begin
      cnt_q    <= '0;
      reload_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign expired_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/run_watchdog.sv
// Supervises one kernel run: countdown armed on start, abort handshake on expiry.
// Define WDOG_CYCLE_CNT_EN to add the saturating elapsed-cycle counter.
module run_watchdog
  import wdog_pkg::*;
#(
  parameter logic [CNT_W-1:0] DEFAULT_TO = wdog_pkg::DEFAULT_TO,
  parameter int               CYC_W      = 48
) (
  input  logic          aclk,
  input  logic          ap_rst_n,
  run_watchdog_if.slave bus
);

  wdog_state_t      state_q, state_d;
  logic             status_timeout_q, status_timeout_d;
  logic             start_acc;
  logic             cnt_reload, cnt_dec, cnt_expired;
  logic [CNT_W-1:0] cnt;

  // Starts are only honoured between runs; DONE may chain straight into RUN.
  assign start_acc  = bus.ap_start && ((state_q == IDLE) || (state_q == DONE));
  assign cnt_reload = (state_q == RUN) && !bus.kernel_done && bus.progress;
  assign cnt_dec    = (state_q == RUN) && !bus.kernel_done && !bus.progress && !cnt_expired;

  wdog_countdown u_countdown (
    .clk        (aclk),
    .rst_n      (ap_rst_n),
    .load_i     (start_acc),
    .load_val_i (sel_timeout(bus.timeout_cfg, DEFAULT_TO)),
    .reload_i   (cnt_reload),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt),
    .expired_o  (cnt_expired)
  );

  always_ff @(posedge aclk) begin
    if (!ap_rst_n) begin
      state_q          <= IDLE;
      status_timeout_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      status_timeout_q <= status_timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.ap_start) state_d = RUN;
      RUN: begin
        if (bus.kernel_done)   state_d = DONE;
        else if (bus.progress) state_d = RUN;
        else if (cnt_expired)  state_d = ABORT;
      end
      ABORT: if (bus.abort_ack) state_d = DONE;
      DONE:  state_d = bus.ap_start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    status_timeout_d = status_timeout_q;
    if (start_acc)
      status_timeout_d = 1'b0;
    else if ((state_q == ABORT) && bus.abort_ack)
      status_timeout_d = 1'b1;
  end

  always_comb begin
    bus.abort_req      = (state_q == ABORT);
    bus.ap_idle        = (state_q == IDLE);
    bus.ap_done        = (state_q == DONE);
    bus.status_timeout = status_timeout_q;
  end

`ifdef WDOG_CYCLE_CNT_EN
  logic [CYC_W-1:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q;
    if (start_acc)
      cycles_d = '0;
    else if (((state_q == RUN) || (state_q == ABORT)) && (cycles_q != '1))
      cycles_d = cycles_q + 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (!ap_rst_n) cycles_q <= '0;
    else           cycles_q <= cycles_d;
  end

  assign bus.cycles = cycles_q;
`endif

endmodule

// File: tb/tb_run_watchdog.sv
// Directed self-checking bench for run_watchdog (DEFAULT_TO overridden to 6).
module tb_run_watchdog;
  import wdog_pkg::*;

  logic aclk;
  logic ap_rst_n;
  int   total;
  int   bad;

  run_watchdog_if #(.CYC_W(48)) bus ();

  run_watchdog #(
    .DEFAULT_TO (32'd6),
    .CYC_W      (48)
  ) dut (
    .aclk     (aclk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Apply one cycle of pulse inputs, advance past the edge, then drop them.
  task automatic drv(input logic s, input logic p, input logic k, input logic a);
    bus.ap_start    = s;
    bus.progress    = p;
    bus.kernel_done = k;
    bus.abort_ack   = a;
    step();
    bus.ap_start    = 1'b0;
    bus.progress    = 1'b0;
    bus.kernel_done = 1'b0;
    bus.abort_ack   = 1'b0;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    step();
    step();
    ap_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.ap_start = 1'b1;
    bus.abort_ack = 1'b1;
    do_reset();
    bus.ap_start = 1'b0;
    bus.abort_ack = 1'b0;
    total++; if (bus.abort_req !== 1'b0) begin bad++; $display("FAIL reset abort_req got=%b want=0", bus.abort_req); end
    total++; if (bus.ap_idle !== 1'b1) begin bad++; $display("FAIL reset ap_idle got=%b want=1", bus.ap_idle); end
    total++; if (bus.ap_done !== 1'b0) begin bad++; $display("FAIL reset ap_done got=%b want=0", bus.ap_done); end
    total++; if (bus.status_timeout !== 1'b0) begin bad++; $display("FAIL reset status got=%b want=0", bus.status_timeout); end
`ifdef WDOG_CYCLE_CNT_EN
    total++; if (bus.cycles !== 48'd0) begin bad++; $display("FAIL reset cycles got=%0d want=0", bus.cycles); end
`endif
  endtask

  // cfg=10, start@0, kernel_done together with progress @5
  task automatic test_normal();
    bus.timeout_cfg = 32'd10;
    for (int c = 0; c <= 7; c++) begin
      total++; if (bus.abort_req !== 1'b0) begin bad++; $display("FAIL normal c=%0d abort_req got=%b want=0", c, bus.abort_req); end
      total++; if (bus.ap_done !== (c == 6)) begin bad++; $display("FAIL normal c=%0d ap_done got=%b want=%b", c, bus.ap_done, (c == 6)); end
      total++; if (bus.ap_idle !== (c == 0 || c == 7)) begin bad++; $display("FAIL normal c=%0d ap_idle got=%b want=%b", c, bus.ap_idle, (c == 0 || c == 7)); end
      if (c == 6) begin
        total++; if (bus.status_timeout !== 1'b0) begin bad++; $display("FAIL normal status got=%b want=0", bus.status_timeout); end
`ifdef WDOG_CYCLE_CNT_EN
        total++; if (bus.cycles !== 48'd5) begin bad++; $display("FAIL normal cycles got=%0d want=5", bus.cycles); end
`endif
      end
      drv(c == 0, c == 5, c == 5, 1'b0);
    end
  endtask

  // cfg=4, no progress; kernel_done/progress/start in ABORT are ignored; ack @8
  task automatic test_timeout();
    bus.timeout_cfg = 32'd4;
    for (int c = 0; c <= 11; c++) begin
      total++; if (bus.abort_req !== (c >= 5 && c <= 8)) begin bad++; $display("FAIL timeout c=%0d abort_req got=%b want=%b", c, bus.abort_req, (c >= 5 && c <= 8)); end
      total++; if (bus.ap_done !== (c == 9)) begin bad++; $display("FAIL timeout c=%0d ap_done got=%b want=%b", c, bus.ap_done, (c == 9)); end
      if (c >= 9) begin
        total++; if (bus.status_timeout !== 1'b1) begin bad++; $display("FAIL timeout c=%0d status got=%b want=1", c, bus.status_timeout); end
      end
`ifdef WDOG_CYCLE_CNT_EN
      if (c == 9) begin
        total++; if (bus.cycles !== 48'd8) begin bad++; $display("FAIL timeout cycles got=%0d want=8", bus.cycles); end
      end
`endif
      drv(c == 0 || c == 7, c == 7, c == 6, c == 8);
    end
  endtask

  // cfg=4, progress @3 and @6, stray start @4 in RUN; ack @12
  task automatic test_reload();
    bus.timeout_cfg = 32'd4;
    for (int c = 0; c <= 14; c++) begin
      total++; if (bus.abort_req !== (c == 11 || c == 12)) begin bad++; $display("FAIL reload c=%0d abort_req got=%b want=%b", c, bus.abort_req, (c == 11 || c == 12)); end
      total++; if (bus.ap_done !== (c == 13)) begin bad++; $display("FAIL reload c=%0d ap_done got=%b want=%b", c, bus.ap_done, (c == 13)); end
      total++; if (bus.status_timeout !== (c == 0 || c >= 13)) begin bad++; $display("FAIL reload c=%0d status got=%b want=%b", c, bus.status_timeout, (c == 0 || c >= 13)); end
      drv(c == 0 || c == 4, c == 3 || c == 6, 1'b0, c == 12);
    end
  endtask

  // cfg=4, kernel_done @4 exactly when cnt==1
  task automatic test_simultaneous();
    bus.timeout_cfg = 32'd4;
    for (int c = 0; c <= 6; c++) begin
      total++; if (bus.abort_req !== 1'b0) begin bad++; $display("FAIL simul c=%0d abort_req got=%b want=0", c, bus.abort_req); end
      total++; if (bus.ap_done !== (c == 5)) begin bad++; $display("FAIL simul c=%0d ap_done got=%b want=%b", c, bus.ap_done, (c == 5)); end
      if (c >= 1) begin
        total++; if (bus.status_timeout !== 1'b0) begin bad++; $display("FAIL simul c=%0d status got=%b want=0", c, bus.status_timeout); end
      end
      drv(c == 0, 1'b0, c == 4, 1'b0);
    end
  endtask

  // cfg=2, ABORT @3, reset during @5, stray ack @6 in IDLE, fresh run from @7
  task automatic test_reset_mid_abort();
    bus.timeout_cfg = 32'd2;
    for (int c = 0; c <= 12; c++) begin
      total++; if (bus.abort_req !== ((c >= 3 && c <= 5) || c == 10)) begin bad++; $display("FAIL rstabort c=%0d abort_req got=%b want=%b", c, bus.abort_req, ((c >= 3 && c <= 5) || c == 10)); end
      total++; if (bus.ap_idle !== (c == 0 || c == 6 || c == 7 || c == 12)) begin bad++; $display("FAIL rstabort c=%0d ap_idle got=%b want=%b", c, bus.ap_idle, (c == 0 || c == 6 || c == 7 || c == 12)); end
      total++; if (bus.ap_done !== (c == 11)) begin bad++; $display("FAIL rstabort c=%0d ap_done got=%b want=%b", c, bus.ap_done, (c == 11)); end
      total++; if (bus.status_timeout !== (c >= 11)) begin bad++; $display("FAIL rstabort c=%0d status got=%b want=%b", c, bus.status_timeout, (c >= 11)); end
      if (c == 5) ap_rst_n = 1'b0;
      drv(c == 0 || c == 7, 1'b0, 1'b0, c == 6 || c == 10);
      ap_rst_n = 1'b1;
    end
  endtask

  // cfg=0 selects DEFAULT_TO=6; second start lands in the DONE cycle @8
  task automatic test_back_to_back();
    bus.timeout_cfg = 32'd0;
    for (int c = 0; c <= 16; c++) begin
      total++; if (bus.abort_req !== (c == 7 || c >= 15)) begin bad++; $display("FAIL b2b c=%0d abort_req got=%b want=%b", c, bus.abort_req, (c == 7 || c >= 15)); end
      total++; if (bus.ap_done !== (c == 8)) begin bad++; $display("FAIL b2b c=%0d ap_done got=%b want=%b", c, bus.ap_done, (c == 8)); end
      total++; if (bus.ap_idle !== (c == 0)) begin bad++; $display("FAIL b2b c=%0d ap_idle got=%b want=%b", c, bus.ap_idle, (c == 0)); end
      if (c == 8 || c == 9) begin
        total++; if (bus.status_timeout !== (c == 8)) begin bad++; $display("FAIL b2b c=%0d status got=%b want=%b", c, bus.status_timeout, (c == 8)); end
      end
      drv(c == 0 || c == 8, 1'b0, 1'b0, c == 7);
    end
    do_reset();
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    ap_rst_n        = 1'b0;
    bus.ap_start    = 1'b0;
    bus.timeout_cfg = '0;
    bus.progress    = 1'b0;
    bus.kernel_done = 1'b0;
    bus.abort_ack   = 1'b0;
    test_reset();
    test_normal();
    test_timeout();
    test_reload();
    test_simultaneous();
    test_reset_mid_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
